// File: rtl/vga_timing_monitor_if.sv
// Video tap between a VGA source (master) and the timing monitor (slave).
interface vga_timing_monitor_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        clr_err;
    logic        locked;
    logic        de;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic        err_h;
    logic        err_v;
    logic        err_blank;
    logic [15:0] frame_count;

    modport master (
        output pix_en, hsync, vsync, blank, clr_err,
        input  locked, de, pixel_x, pixel_y, frame_start,
        input  err_h, err_v, err_blank, frame_count
    );

    modport slave (
        input  pix_en, hsync, vsync, blank, clr_err,
        output locked, de, pixel_x, pixel_y, frame_start,
        output err_h, err_v, err_blank, frame_count
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// Rebuilds raster position from an hsync/vsync/blank stream and checks it
// against the configured VGA timing, reporting lock, frame starts and errors.
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_timing_monitor_if.slave  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LINE_END  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC - 1);
    localparam logic [9:0] V_FRAME_END = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC - 1);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;
    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_FRAMES);
    localparam logic       SYNC_LVL    = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t      r_state;
    logic        r_hs;
    logic        r_vs_line;
    logic        r_blank;
    logic        r_h_seen;
    logic        r_v_seen;
    logic        r_chk_blank;
    logic        r_locked;
    logic        r_frame_start;
    logic        r_err_h;
    logic        r_err_v;
    logic        r_err_blank;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [7:0]  r_good;
    logic [15:0] r_frame_count;

    logic        w_tick;
    logic        w_hs;
    logic        w_vs;
    logic        w_h_rise;
    logic        w_h_fall;
    logic        w_v_rise;
    logic        w_v_fall;
    logic        w_h_fail;
    logic        w_v_fail;
    logic        w_fail;
    logic        w_de;
    logic        w_blank_bad;
    logic        w_set_err_h;
    logic        w_set_err_v;
    logic [9:0]  w_h_inc;
    logic [9:0]  w_v_inc;
    logic [7:0]  w_good_inc;

    always_comb begin
        w_tick   = bus.pix_en;
        w_hs     = (bus.hsync == SYNC_LVL);
        w_vs     = (bus.vsync == SYNC_LVL);
        w_h_rise = w_tick & w_hs & ~r_hs;
        w_h_fall = w_tick & ~w_hs & r_hs;
        // Vertical edges only exist on line boundaries (hsync assertion ticks).
        w_v_rise = w_h_rise & w_vs & ~r_vs_line;
        w_v_fall = w_h_rise & ~w_vs & r_vs_line;
        w_h_fail = r_h_seen & ((w_h_rise & (r_h_cnt != H_LINE_END)) |
                               (w_h_fall & (r_h_cnt != H_SYNC_END)));
        w_v_fail = r_v_seen & ((w_v_rise & (r_v_cnt != V_FRAME_END)) |
                               (w_v_fall & (r_v_cnt != V_SYNC_END)));
        w_fail      = w_h_fail | w_v_fail;
        w_set_err_h = w_h_fail & (r_state == S_LOCKED);
        w_set_err_v = w_v_fail & (r_state == S_LOCKED);
        w_h_inc     = (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 10'd1;
        w_v_inc     = (r_v_cnt == CNT_MAX) ? CNT_MAX : r_v_cnt + 10'd1;
        w_good_inc  = r_good + 8'd1;
        w_de = r_locked &
               (r_h_cnt >= H_VIS_START) & (r_h_cnt <= H_VIS_END) &
               (r_v_cnt >= V_VIS_START) & (r_v_cnt <= V_VIS_END);
        // Compared on the clk after a tick, when r_blank and the counters match.
        w_blank_bad = r_chk_blank & r_locked & (r_blank != w_de);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SEARCH;
            r_hs          <= 1'b0;
            r_vs_line     <= 1'b0;
            r_blank       <= 1'b0;
            r_h_seen      <= 1'b0;
            r_v_seen      <= 1'b0;
            r_chk_blank   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_err_h       <= 1'b0;
            r_err_v       <= 1'b0;
            r_err_blank   <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_good        <= '0;
            r_frame_count <= '0;
        end else begin
            r_chk_blank   <= w_tick;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_hs    <= w_hs;
                r_blank <= bus.blank;
                r_h_cnt <= w_h_rise ? 10'd0 : w_h_inc;
                if (w_h_rise) begin
                    r_vs_line <= w_vs;
                    r_v_cnt   <= w_v_rise ? 10'd0 : w_v_inc;
                    r_h_seen  <= 1'b1;
                end
                if (w_v_rise) begin
                    r_v_seen <= 1'b1;
                end
                case (r_state)
                    S_SEARCH: begin
                        if (w_v_rise) begin
                            r_state <= S_ACQUIRE;
                            r_good  <= '0;
                        end
                    end
                    S_ACQUIRE: begin
                        if (w_fail) begin
                            r_state  <= S_SEARCH;
                            r_h_seen <= 1'b0;
                            r_v_seen <= 1'b0;
                        end else if (w_v_rise) begin
                            r_good <= w_good_inc;
                            if (w_good_inc >= LOCK_TARGET) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (w_fail) begin
                            r_state  <= S_SEARCH;
                            r_locked <= 1'b0;
                            r_h_seen <= 1'b0;
                            r_v_seen <= 1'b0;
                        end else if (w_v_rise) begin
                            r_frame_start <= 1'b1;
                            if (r_frame_count != 16'hFFFF) begin
                                r_frame_count <= r_frame_count + 16'd1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            // A new error on the same clk as clr_err keeps the flag set.
            r_err_h     <= (r_err_h & ~bus.clr_err) | w_set_err_h;
            r_err_v     <= (r_err_v & ~bus.clr_err) | w_set_err_v;
            r_err_blank <= (r_err_blank & ~bus.clr_err) | w_blank_bad;
        end
    end

    assign bus.locked      = r_locked;
    assign bus.de          = w_de;
    assign bus.pixel_x     = w_de ? (r_h_cnt - H_VIS_START) : 10'd0;
    assign bus.pixel_y     = w_de ? (r_v_cnt - V_VIS_START) : 10'd0;
    assign bus.frame_start = r_frame_start;
    assign bus.err_h       = r_err_h;
    assign bus.err_v       = r_err_v;
    assign bus.err_blank   = r_err_blank;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomised-pix_en VGA stream with fault injection, checked every clk against
// a tick/line-index reference model; two monitors (active-low and active-high sync).
module tb_vga_timing_monitor;
    localparam int HA = 16, HF = 3, HS = 5, HB = 4;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int LF = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HV0 = HS + HB;
    localparam int VV0 = VS + VB;
    localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_monitor_if bus0 ();
    vga_timing_monitor_if bus1 ();

    vga_timing_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .LOCK_FRAMES(LF)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    vga_timing_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .LOCK_FRAMES(LF)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // {locked, de, pixel_x, pixel_y, frame_start, err_h, err_v, err_blank, frame_count}
    logic [41:0] obs0, obs1;
    assign obs0 = {bus0.locked, bus0.de, bus0.pixel_x, bus0.pixel_y, bus0.frame_start,
                   bus0.err_h, bus0.err_v, bus0.err_blank, bus0.frame_count};
    assign obs1 = {bus1.locked, bus1.de, bus1.pixel_x, bus1.pixel_y, bus1.frame_start,
                   bus1.err_h, bus1.err_v, bus1.err_blank, bus1.frame_count};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [41:0] obs, input logic [41:0] want);
        n_vec++;
        if (obs !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference model: positions are tick/line distances from the last sync edge.
    int m_t = 0, m_hrise = 0, m_l = 0, m_vrise = 0;
    int m_mode = M_SEARCH, m_good = 0, m_fc = 0;
    bit m_hs = 0, m_vsl = 0, m_bl = 0, m_hseen = 0, m_vseen = 0;
    bit m_fs = 0, m_eh = 0, m_ev = 0, m_eb = 0, m_chk = 0;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic bit model_de();
        int hc;
        int vc;
        hc = sat(m_t - m_hrise);
        vc = sat(m_l - m_vrise);
        return (m_mode == M_LOCK) && (hc >= HV0) && (hc < HV0 + HA) &&
               (vc >= VV0) && (vc < VV0 + VA);
    endfunction

    function automatic logic [41:0] model_out();
        bit         de;
        logic [9:0] px;
        logic [9:0] py;
        de = model_de();
        px = de ? 10'(sat(m_t - m_hrise) - HV0) : 10'd0;
        py = de ? 10'(sat(m_l - m_vrise) - VV0) : 10'd0;
        return {(m_mode == M_LOCK), de, px, py, m_fs, m_eh, m_ev, m_eb, 16'(m_fc)};
    endfunction

    task automatic model_clk(input bit r, input bit pe, input bit a_hs, input bit a_vs,
                             input bit bl, input bit clr);
        bit rise, fall, vrise, vfall, hfail, vfail;
        bit seh, sev, seb, fs;
        int hlen, vlen;
        if (r) begin
            m_t = 0; m_hrise = 0; m_l = 0; m_vrise = 0;
            m_mode = M_SEARCH; m_good = 0; m_fc = 0;
            m_hs = 0; m_vsl = 0; m_bl = 0; m_hseen = 0; m_vseen = 0;
            m_fs = 0; m_eh = 0; m_ev = 0; m_eb = 0; m_chk = 0;
            return;
        end
        seh = 0; sev = 0; fs = 0;
        seb = m_chk && (m_mode == M_LOCK) && (m_bl != model_de());
        if (pe) begin
            rise  = a_hs && !m_hs;
            fall  = !a_hs && m_hs;
            vrise = rise && a_vs && !m_vsl;
            vfall = rise && !a_vs && m_vsl;
            hlen  = m_t + 1 - m_hrise;
            vlen  = m_l + 1 - m_vrise;
            hfail = m_hseen && ((rise && hlen != HT) || (fall && hlen != HS));
            vfail = m_vseen && ((vrise && vlen != VT) || (vfall && vlen != VS));
            m_t++;
            if (rise) begin
                m_hrise = m_t;
                m_l++;
                m_vsl   = a_vs;
                m_hseen = 1;
            end
            if (vrise) begin
                m_vrise = m_l;
                m_vseen = 1;
            end
            m_hs = a_hs;
            m_bl = bl;
            if (m_mode == M_SEARCH) begin
                if (vrise) begin
                    m_mode = M_ACQ;
                    m_good = 0;
                end
            end else if (hfail || vfail) begin
                if (m_mode == M_LOCK) begin
                    seh = hfail;
                    sev = vfail;
                end
                m_mode  = M_SEARCH;
                m_hseen = 0;
                m_vseen = 0;
            end else if (vrise) begin
                if (m_mode == M_ACQ) begin
                    m_good++;
                    if (m_good >= LF) m_mode = M_LOCK;
                end else begin
                    fs = 1;
                    if (m_fc < 65535) m_fc++;
                end
            end
        end
        m_fs  = fs;
        m_chk = pe;
        m_eh  = (m_eh && !clr) || seh;
        m_ev  = (m_ev && !clr) || sev;
        m_eb  = (m_eb && !clr) || seb;
    endtask

    // One clk: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input bit r, input bit pe, input bit hs, input bit vs,
                         input bit bl, input bit clr);
        logic [41:0] want;
        rst = r;
        bus0.pix_en = pe; bus0.hsync = ~hs; bus0.vsync = ~vs; bus0.blank = bl; bus0.clr_err = clr;
        bus1.pix_en = pe; bus1.hsync = hs;  bus1.vsync = vs;  bus1.blank = bl; bus1.clr_err = clr;
        @(posedge clk);
        model_clk(r, pe, hs, vs, bl, clr);
        @(negedge clk);
        want = model_out();
        check_eq("out_pol0", obs0, want);
        check_eq("out_pol1", obs1, want);
    endtask

    task automatic tick(input bit hs, input bit vs, input bit bl, input bit clr);
        while ($urandom_range(0, 3) == 0) cycle(0, 0, hs, vs, bl, 0);
        cycle(0, 1, hs, vs, bl, clr);
    endtask

    task automatic check_both(input string tag, input logic [41:0] want);
        check_eq(tag, 42'({obs0[40:20]}), want);
        check_eq(tag, 42'({obs1[40:20]}), want);
    endtask

    task automatic send_frame(input int short_line, input int vs_lines, input int gx,
                              input int gy, input bit clr_on_err, input int rst_line,
                              input int stall_line, input bit probe);
        for (int y = 0; y < VT; y++) begin
            int len;
            len = (y == short_line) ? HT - 1 : HT;
            if (y == rst_line) begin
                cycle(1, 0, 0, 0, 0, 0);
                check_eq("reset_zero_pol0", obs0, 42'd0);
                check_eq("reset_zero_pol1", obs1, 42'd0);
            end
            for (int x = 0; x < len; x++) begin
                bit hs, vs, bl, clr;
                hs  = (x < HS);
                vs  = (y < vs_lines);
                bl  = (x >= HV0) && (x < HV0 + HA) && (y >= VV0) && (y < VV0 + VA) &&
                      !(gx >= 0 && x == HV0 + gx && y == VV0 + gy);
                clr = clr_on_err && (short_line >= 0) && (y == short_line + 1) && (x == 0);
                if (y == stall_line && x == HS + 2) begin
                    repeat (50) cycle(0, 0, hs, vs, bl, 0);
                end
                tick(hs, vs, bl, clr);
                if (probe && x == HV0 && y == VV0)
                    check_both("first_pixel", 42'({1'b1, 10'd0, 10'd0}));
                if (probe && x == HV0 + HA - 1 && y == VV0 + VA - 1)
                    check_both("last_pixel", 42'({1'b1, 10'(HA - 1), 10'(VA - 1)}));
            end
        end
    endtask

    task automatic nominal(input bit probe);
        send_frame(-1, VS, -1, -1, 0, -1, -1, probe);
    endtask

    task automatic pulse_clr();
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    // want = {locked, err_h, err_v, err_blank}
    task automatic check_status(input string tag, input logic [3:0] want, input int fc);
        check_eq({tag, "_flags0"}, 42'({obs0[41], obs0[18:16]}), 42'(want));
        check_eq({tag, "_flags1"}, 42'({obs1[41], obs1[18:16]}), 42'(want));
        check_eq({tag, "_count0"}, 42'(obs0[15:0]), 42'(fc));
        check_eq({tag, "_count1"}, 42'(obs1[15:0]), 42'(fc));
    endtask

    initial begin
        @(negedge clk);
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        check_status("reset", 4'b0000, 0);

        nominal(0);
        nominal(0);
        check_status("before_lock", 4'b0000, 0);
        nominal(1);
        check_status("lock_3rd_edge", 4'b1000, 0);
        nominal(1);
        check_status("nominal_4", 4'b1000, 1);

        send_frame(4, VS, -1, -1, 0, -1, -1, 0);
        check_status("short_line", 4'b0100, 2);
        repeat (3) nominal(0);
        check_status("relock_err_h_sticky", 4'b1100, 2);
        pulse_clr();
        check_status("clr_err_h", 4'b1000, 2);

        send_frame(-1, 3, -1, -1, 0, -1, -1, 0);
        check_status("long_vsync", 4'b0010, 3);
        repeat (3) nominal(0);
        check_status("relock_v", 4'b1010, 3);
        pulse_clr();

        send_frame(-1, VS, 5, 3, 0, -1, -1, 0);
        check_status("blank_glitch", 4'b1001, 4);
        pulse_clr();

        send_frame(-1, VS, -1, -1, 0, 5, -1, 0);
        check_status("after_reset", 4'b0000, 0);
        repeat (2) nominal(0);
        check_status("reacquire", 4'b0000, 0);
        nominal(0);
        check_status("relock_after_reset", 4'b1000, 0);

        send_frame(6, VS, -1, -1, 1, -1, -1, 0);
        check_status("clr_with_error", 4'b0100, 1);
        pulse_clr();

        repeat (5) send_frame(-1, VS, -1, -1, 0, -1, 4, 0);
        check_status("stalled_stream", 4'b1000, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
